// File: rtl/btb_fetch_pc.sv
// Fetch-stage next-PC generator with a direct-mapped branch target buffer.
// Owns the IF program counter, predicts taken branches from BTB hits combined
// with the direction predictor's hint, carries the prediction through ID and
// EX, and raises a redirect when EX resolution disagrees with the prediction.
module btb_fetch_pc #(
  parameter int          s_btb_idx   = 4,
  parameter int          s_pc_offset = 2,
  parameter logic [31:0] reset_pc    = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        stall_ex,
  input  logic        br_take,
  input  logic        update,
  input  logic        br_en,
  input  logic [31:0] ex_target,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam int entries = 1 << s_btb_idx;
  localparam int tag_lo  = s_btb_idx + s_pc_offset;
  localparam int tag_w   = 32 - tag_lo;

  // IF program counter
  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  // Prediction metadata carried through ID and EX
  logic [31:0] id_pc_reg;
  logic        id_taken_reg;
  logic [31:0] id_target_reg;
  logic [31:0] ex_pc_reg;
  logic        ex_taken_reg;
  logic [31:0] ex_target_reg;

  // BTB read view, one element per entry
  logic [entries-1:0] entry_valid;
  logic [tag_w-1:0]   entry_tag    [entries];
  logic [31:0]        entry_target [entries];

  // Lookup side (current fetch PC)
  logic [s_btb_idx-1:0] if_idx;
  logic [tag_w-1:0]     if_tag;
  logic                 hit;
  logic [31:0]          pc_plus4;
  logic [31:0]          pred_target;

  // Update side (EX-stage PC)
  logic [s_btb_idx-1:0] ex_idx;
  logic [tag_w-1:0]     ex_tag;
  logic                 btb_we;
  logic [entries-1:0]   we_vec;
  logic                 dir_wrong;
  logic                 tgt_wrong;

  assign pc       = pc_reg;
  assign if_idx   = pc_reg[tag_lo-1:s_pc_offset];
  assign if_tag   = pc_reg[31:tag_lo];
  assign pc_plus4 = pc_reg + 32'd4;

  // Combinational BTB lookup; a miss forces a not-taken prediction
  always_comb begin
    hit         = entry_valid[if_idx] && (entry_tag[if_idx] == if_tag);
    pred_taken  = br_take & hit;
    pred_target = hit ? entry_target[if_idx] : pc_plus4;
  end

  assign ex_idx = ex_pc_reg[tag_lo-1:s_pc_offset];
  assign ex_tag = ex_pc_reg[31:tag_lo];

  // Resolve EX prediction against the actual outcome
  always_comb begin
    dir_wrong   = (ex_taken_reg != br_en);
    tgt_wrong   = br_en & ex_taken_reg & (ex_target_reg != ex_target);
    redirect    = update & (dir_wrong | tgt_wrong);
    redirect_pc = br_en ? ex_target : (ex_pc_reg + 32'd4);
  end

  // Every taken resolution (re)writes the entry, correct prediction or not
  assign btb_we = update & br_en;
  assign we_vec = btb_we ? (entries'(1) << ex_idx) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < entries; gi++) begin : g_btb
      logic             valid_reg;
      logic [tag_w-1:0] tag_reg;
      logic [31:0]      target_reg;

      // One BTB entry: reset clears only the valid bit; reset also drops a coincident write
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
        end else if (we_vec[gi]) begin
          valid_reg  <= 1'b1;
          tag_reg    <= ex_tag;
          target_reg <= ex_target;
        end
      end

      assign entry_valid[gi]  = valid_reg;
      assign entry_tag[gi]    = tag_reg;
      assign entry_target[gi] = target_reg;
    end
  endgenerate

  // Next fetch address: redirect beats stall, stall beats prediction
  always_comb begin
    pc_next = pc_plus4;
    if (redirect)        pc_next = redirect_pc;
    else if (stall_if)   pc_next = pc_reg;
    else if (pred_taken) pc_next = pred_target;
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) pc_reg <= reset_pc;
    else     pc_reg <= pc_next;
  end

  // IF->ID metadata register, held while ID is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_reg     <= 32'd0;
      id_taken_reg  <= 1'b0;
      id_target_reg <= 32'd0;
    end else if (!stall_id) begin
      id_pc_reg     <= pc_reg;
      id_taken_reg  <= pred_taken;
      id_target_reg <= pred_target;
    end
  end

  // ID->EX metadata register, held while EX is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pc_reg     <= 32'd0;
      ex_taken_reg  <= 1'b0;
      ex_target_reg <= 32'd0;
    end else if (!stall_ex) begin
      ex_pc_reg     <= id_pc_reg;
      ex_taken_reg  <= id_taken_reg;
      ex_target_reg <= id_target_reg;
    end
  end

endmodule

// File: tb/tb_btb_fetch_pc.sv
// Directed bench for btb_fetch_pc: cold miss, warm hit, direction and target
// mispredicts, IF stall, redirect under stall, aliasing, PC wrap and
// mid-operation reset. Inputs change 1 time unit after posedge, outputs are
// checked 1 more unit later.
module tb_btb_fetch_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, stall_ex;
  logic        br_take, update, br_en;
  logic [31:0] ex_target;
  logic [31:0] pc;
  logic        pred_taken, redirect;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  btb_fetch_pc dut (
    .clk         (clk),
    .rst         (rst),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .br_take     (br_take),
    .update      (update),
    .br_en       (br_en),
    .ex_target   (ex_target),
    .pc          (pc),
    .pred_taken  (pred_taken),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_if = 0; stall_id = 0; stall_ex = 0;
    br_take = 0; update = 0; br_en = 0; ex_target = 32'd0;

    // Reset, then free run
    tick(); rst = 1'b0; #1;
    check_val("rst_pc", pc, 32'h60);
    check_val("rst_pred", {31'd0, pred_taken}, 32'd0);
    check_val("rst_redir", {31'd0, redirect}, 32'd0);
    tick(); #1; check_val("run_pc64", pc, 32'h64);
    tick(); #1; check_val("run_pc68", pc, 32'h68);
    repeat (6) tick();

    // Cold taken branch at 0x80 -> 0x200
    br_take = 1; #1;
    check_val("cold_pc", pc, 32'h80);
    check_val("cold_pred", {31'd0, pred_taken}, 32'd0);
    tick(); br_take = 0;
    tick(); update = 1; br_en = 1; ex_target = 32'h200; #1;   // EX holds 0x80
    check_val("cold_redir", {31'd0, redirect}, 32'd1);
    check_val("cold_rpc", redirect_pc, 32'h200);
    tick(); #1; check_val("cold_newpc", pc, 32'h200);
    ex_target = 32'h80; #1;                                   // EX holds 0x84, steer back
    check_val("steer1_redir", {31'd0, redirect}, 32'd1);

    // Warm hit at 0x80
    tick(); update = 0; br_take = 1; #1;
    check_val("warm_pc", pc, 32'h80);
    check_val("warm_pred", {31'd0, pred_taken}, 32'd1);
    tick(); br_take = 0; #1; check_val("warm_next", pc, 32'h200);
    tick(); update = 1; br_en = 1; ex_target = 32'h200; #1;   // EX holds 0x80, predicted right
    check_val("warm_noredir", {31'd0, redirect}, 32'd0);
    tick(); update = 0; #1; check_val("warm_seq", pc, 32'h208);
    tick(); update = 1; br_en = 1; ex_target = 32'h80; #1;    // EX holds 0x204
    check_val("steer2_redir", {31'd0, redirect}, 32'd1);

    // Direction mispredict: predicted taken, resolves not taken
    tick(); update = 0; br_take = 1; #1;
    check_val("dir_pred", {31'd0, pred_taken}, 32'd1);
    tick(); br_take = 0;
    tick(); update = 1; br_en = 0; #1;
    check_val("dir_redir", {31'd0, redirect}, 32'd1);
    check_val("dir_rpc", redirect_pc, 32'h84);
    tick(); update = 0; #1; check_val("dir_pc", pc, 32'h84);
    tick(); update = 1; br_en = 1; ex_target = 32'h80;        // EX holds 0x204
    tick(); update = 0; br_take = 1; #1;
    check_val("dir_entry_kept", {31'd0, pred_taken}, 32'd1);
    tick(); br_take = 0; #1; check_val("dir_entry_tgt", pc, 32'h200);

    // Target mispredict: predicted 0x200, resolves to 0x300
    tick(); update = 1; br_en = 1; ex_target = 32'h300; #1;
    check_val("tgt_redir", {31'd0, redirect}, 32'd1);
    check_val("tgt_rpc", redirect_pc, 32'h300);
    tick(); update = 0; #1; check_val("tgt_pc", pc, 32'h300);
    tick(); update = 1; br_en = 1; ex_target = 32'h80;        // EX holds 0x204
    tick(); update = 0; br_take = 1; #1;
    check_val("tgt_rewr_pred", {31'd0, pred_taken}, 32'd1);

    // IF stall for three cycles
    tick(); br_take = 0; stall_if = 1; #1;
    check_val("tgt_rewr_pc", pc, 32'h300);
    tick(); #1; check_val("stall_pc1", pc, 32'h300);
    tick(); #1; check_val("stall_pc2", pc, 32'h300);
    tick(); #1; check_val("stall_pc3", pc, 32'h300);

    // Redirect during stall: EX holds 0x300, installs 0x300 (index 0) -> 0x480
    update = 1; br_en = 1; ex_target = 32'h480; #1;
    check_val("stall_redir", {31'd0, redirect}, 32'd1);
    tick(); update = 0; stall_if = 0; br_take = 1; #1;
    check_val("stall_redir_pc", pc, 32'h480);
    check_val("alias480_pred", {31'd0, pred_taken}, 32'd0);
    tick(); br_take = 0; #1; check_val("alias_seq", pc, 32'h484);
    tick(); update = 1; br_en = 1; ex_target = 32'h600; #1;   // EX holds 0x480
    check_val("alias_redir", {31'd0, redirect}, 32'd1);
    tick(); ex_target = 32'h80; #1;                           // EX holds 0x484
    check_val("alias_pc600", pc, 32'h600);
    tick(); update = 0; br_take = 1; #1;
    check_val("alias_pc80", pc, 32'h80);
    check_val("alias80_miss", {31'd0, pred_taken}, 32'd0);

    // PC wrap
    tick(); br_take = 0; #1;
    check_val("alias_nt_seq", pc, 32'h84);
    update = 1; br_en = 1; ex_target = 32'hFFFF_FFFC;
    tick(); update = 0; #1; check_val("wrap_top", pc, 32'hFFFF_FFFC);
    tick(); #1; check_val("wrap_zero", pc, 32'h0);

    // Reset mid-operation with a redirect in flight
    update = 1; br_en = 1; ex_target = 32'h500; #1;
    check_val("inflight_redir", {31'd0, redirect}, 32'd1);
    rst = 1;
    tick(); rst = 0; update = 1; br_en = 0; #1;
    check_val("mid_rst_pc", pc, 32'h60);
    check_val("mid_rst_redir", {31'd0, redirect}, 32'd0);
    check_val("mid_rst_expc", redirect_pc, 32'h4);
    check_val("mid_rst_pred", {31'd0, pred_taken}, 32'd0);
    update = 0;
    repeat (8) tick();
    br_take = 1; #1;
    check_val("clr_pc80", pc, 32'h80);
    check_val("clr_btb_miss", {31'd0, pred_taken}, 32'd0);
    br_take = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
